// File: rtl/rs_pkg.sv
// rtl/rs_pkg.sv - shared RS geometry constants and stream-in FSM state type
package rs_pkg;

   // Reed-Solomon codeword data payload and per-block parity size in bytes
   localparam int RS_DATA_BYTES = 128;
   localparam int PARITY_BYTES  = 8;

   // Geometry for the default 256-bit stream line
   localparam int DEF_DATA_W       = 256;
   localparam int NUM_DATA_LINES   = RS_DATA_BYTES / (DEF_DATA_W / 8);
   localparam int NUM_DATA_LINES_W = $clog2(NUM_DATA_LINES);

   typedef enum logic [1:0] {
      ST_IDLE      = 2'd0,
      ST_WR_DATA   = 2'd1,
      ST_WR_PARITY = 2'd2,
      ST_DONE      = 2'd3
   } rs_state_e;

   // Number of stream lines that make up one block's data payload
   function automatic int data_lines_for(input int data_bytes);
      return RS_DATA_BYTES / data_bytes;
   endfunction

endpackage

// File: rtl/rs_decode_stream_in_ctrl.sv
// rtl/rs_decode_stream_in_ctrl.sv - request/stream/done handshake FSM
module rs_decode_stream_in_ctrl
   import rs_pkg::*;
(
   input  logic clk,
   input  logic rst,
   input  logic src_decode_req_val,
   output logic src_decode_req_rdy,
   input  logic src_decode_data_val,
   output logic src_decode_data_rdy,
   output logic decode_req_done_val,
   input  logic decode_req_done_rdy,
   input  logic datap_ctrl_req_zero,
   input  logic datap_ctrl_last_data_line,
   input  logic datap_ctrl_last_parity_line,
   output logic ctrl_datap_req_acc,
   output logic ctrl_datap_data_acc,
   output logic ctrl_datap_parity_acc
);

   rs_state_e state_q, state_d;
   logic      req_rdy_q, req_rdy_d;
   logic      data_rdy_q, data_rdy_d;
   logic      done_val_q, done_val_d;
   logic      line_acc;

   // Handshakes are masked during reset so nothing is written in the reset cycle
   assign line_acc              = data_rdy_q & src_decode_data_val & ~rst;
   assign ctrl_datap_req_acc    = req_rdy_q & src_decode_req_val & ~rst;
   assign ctrl_datap_data_acc   = line_acc & (state_q == ST_WR_DATA);
   assign ctrl_datap_parity_acc = line_acc & (state_q == ST_WR_PARITY);

   assign src_decode_req_rdy  = req_rdy_q;
   assign src_decode_data_rdy = data_rdy_q;
   assign decode_req_done_val = done_val_q;

   // Next-state and next-output decode; outputs are registered from the next state
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: begin
            if (ctrl_datap_req_acc) begin
               state_d = datap_ctrl_req_zero ? ST_DONE : ST_WR_DATA;
            end
         end
         ST_WR_DATA: begin
            if (ctrl_datap_data_acc && datap_ctrl_last_data_line) begin
               state_d = ST_WR_PARITY;
            end
         end
         ST_WR_PARITY: begin
            if (ctrl_datap_parity_acc && datap_ctrl_last_parity_line) begin
               state_d = ST_DONE;
            end
         end
         ST_DONE: begin
            if (decode_req_done_rdy) begin
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
      req_rdy_d  = (state_d == ST_IDLE);
      data_rdy_d = (state_d == ST_WR_DATA) || (state_d == ST_WR_PARITY);
      done_val_d = (state_d == ST_DONE);
   end

   // State and registered handshake outputs
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= ST_IDLE;
         req_rdy_q  <= 1'b1;
         data_rdy_q <= 1'b0;
         done_val_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         req_rdy_q  <= req_rdy_d;
         data_rdy_q <= data_rdy_d;
         done_val_q <= done_val_d;
      end
   end

endmodule

// File: rtl/rs_decode_stream_in_datap.sv
// rtl/rs_decode_stream_in_datap.sv - block/line/parity counters, write addressing, framing check
module rs_decode_stream_in_datap
   import rs_pkg::*;
#(
   parameter int NUM_REQ_BLOCKS   = 16,
   parameter int NUM_REQ_BLOCKS_W = 4,
   parameter int DATA_W           = 256,
   parameter int NUM_DATA_LINES   = 4,
   parameter int NUM_DATA_LINES_W = 2,
   parameter int PARITY_MEMS      = 4,
   parameter int PARITY_SHIFT     = 2
) (
   input  logic                                   clk,
   input  logic                                   rst,
   input  logic [NUM_REQ_BLOCKS_W:0]              src_decode_req_num_blocks,
   input  logic [DATA_W-1:0]                      src_decode_data,
   input  logic                                   src_decode_data_last,
   input  logic                                   ctrl_datap_req_acc,
   input  logic                                   ctrl_datap_data_acc,
   input  logic                                   ctrl_datap_parity_acc,
   output logic                                   datap_ctrl_req_zero,
   output logic                                   datap_ctrl_last_data_line,
   output logic                                   datap_ctrl_last_parity_line,
   output logic                                   data_mem_wr_val,
   output logic [NUM_REQ_BLOCKS_W+NUM_DATA_LINES_W-1:0] data_mem_wr_addr,
   output logic [DATA_W-1:0]                      data_mem_wr_data,
   output logic                                   parity_mem_wr_val,
   output logic [NUM_REQ_BLOCKS_W-1:0]            parity_mem_wr_addr,
   output logic [DATA_W-1:0]                      parity_mem_wr_data,
   output logic [NUM_REQ_BLOCKS_W:0]              decode_req_done_num_blocks,
   output logic                                   framing_err
);

   localparam int NB_W = NUM_REQ_BLOCKS_W;
   localparam int NL_W = NUM_DATA_LINES_W;
   localparam logic [NB_W:0]   MAX_NB    = (NB_W+1)'(NUM_REQ_BLOCKS);
   localparam logic [NB_W:0]   ONE_NB    = (NB_W+1)'(1);
   localparam logic [NB_W:0]   PAR_ROUND = (NB_W+1)'(PARITY_MEMS - 1);
   localparam logic [NL_W-1:0] LAST_LINE = NL_W'(NUM_DATA_LINES - 1);

   logic [NB_W:0]   num_blocks_q, num_blocks_d;
   logic [NB_W-1:0] block_cnt_q, block_cnt_d;
   logic [NL_W-1:0] line_cnt_q, line_cnt_d;
   logic [NB_W-1:0] parity_cnt_q, parity_cnt_d;
   logic [NB_W:0]   req_num_clamped;
   logic [NB_W:0]   num_parity_lines;
   logic            expected_last;

   // Oversized requests are treated as a full request
   always_comb begin
      req_num_clamped = src_decode_req_num_blocks;
      if (src_decode_req_num_blocks > MAX_NB) begin
         req_num_clamped = MAX_NB;
      end
   end

   assign datap_ctrl_req_zero = (req_num_clamped == '0);

   // Parity lines pack PARITY_MEMS block parities each, so round the block count up
   assign num_parity_lines = (num_blocks_q + PAR_ROUND) >> PARITY_SHIFT;

   assign datap_ctrl_last_data_line   = ({1'b0, block_cnt_q} == (num_blocks_q - ONE_NB)) &&
                                        (line_cnt_q == LAST_LINE);
   assign datap_ctrl_last_parity_line = ({1'b0, parity_cnt_q} == (num_parity_lines - ONE_NB));

   // The sender's last flag is only checked; the latched count decides framing
   assign expected_last = ctrl_datap_parity_acc & datap_ctrl_last_parity_line;
   assign framing_err   = (ctrl_datap_data_acc | ctrl_datap_parity_acc) &
                          (src_decode_data_last != expected_last);

   assign data_mem_wr_val    = ctrl_datap_data_acc;
   assign data_mem_wr_addr   = {block_cnt_q, line_cnt_q};
   assign data_mem_wr_data   = src_decode_data;
   assign parity_mem_wr_val  = ctrl_datap_parity_acc;
   assign parity_mem_wr_addr = parity_cnt_q;
   assign parity_mem_wr_data = src_decode_data;

   assign decode_req_done_num_blocks = num_blocks_q;

   // Counter updates: load on request, walk lines then blocks, then parity lines
   always_comb begin
      num_blocks_d = num_blocks_q;
      block_cnt_d  = block_cnt_q;
      line_cnt_d   = line_cnt_q;
      parity_cnt_d = parity_cnt_q;
      if (ctrl_datap_req_acc) begin
         num_blocks_d = req_num_clamped;
         block_cnt_d  = '0;
         line_cnt_d   = '0;
         parity_cnt_d = '0;
      end else if (ctrl_datap_data_acc) begin
         if (line_cnt_q == LAST_LINE) begin
            line_cnt_d  = '0;
            block_cnt_d = block_cnt_q + NB_W'(1);
         end else begin
            line_cnt_d = line_cnt_q + NL_W'(1);
         end
      end else if (ctrl_datap_parity_acc) begin
         parity_cnt_d = parity_cnt_q + NB_W'(1);
      end
   end

   // Counter and latched block-count registers
   always_ff @(posedge clk) begin
      if (rst) begin
         num_blocks_q <= '0;
         block_cnt_q  <= '0;
         line_cnt_q   <= '0;
         parity_cnt_q <= '0;
      end else begin
         num_blocks_q <= num_blocks_d;
         block_cnt_q  <= block_cnt_d;
         line_cnt_q   <= line_cnt_d;
         parity_cnt_q <= parity_cnt_d;
      end
   end

endmodule

// File: rtl/rs_decode_stream_in.sv
// rtl/rs_decode_stream_in.sv - RS decode stream ingest into data buffer and parity memory
module rs_decode_stream_in
   import rs_pkg::*;
#(
   parameter int NUM_REQ_BLOCKS   = 16,
   parameter int NUM_REQ_BLOCKS_W = $clog2(NUM_REQ_BLOCKS),
   parameter int DATA_W           = 256,
   parameter int DATA_BYTES       = DATA_W / 8,
   parameter int NUM_DATA_LINES_W = $clog2(RS_DATA_BYTES / DATA_BYTES)
) (
   input  logic                                   clk,
   input  logic                                   rst,
   input  logic                                   src_decode_req_val,
   input  logic [NUM_REQ_BLOCKS_W:0]              src_decode_req_num_blocks,
   output logic                                   src_decode_req_rdy,
   input  logic                                   src_decode_data_val,
   input  logic [DATA_W-1:0]                      src_decode_data,
   input  logic                                   src_decode_data_last,
   output logic                                   src_decode_data_rdy,
   output logic                                   data_mem_wr_val,
   output logic [NUM_REQ_BLOCKS_W+NUM_DATA_LINES_W-1:0] data_mem_wr_addr,
   output logic [DATA_W-1:0]                      data_mem_wr_data,
   output logic                                   parity_mem_wr_val,
   output logic [NUM_REQ_BLOCKS_W-1:0]            parity_mem_wr_addr,
   output logic [DATA_W-1:0]                      parity_mem_wr_data,
   output logic                                   decode_req_done_val,
   output logic [NUM_REQ_BLOCKS_W:0]              decode_req_done_num_blocks,
   input  logic                                   decode_req_done_rdy,
   output logic                                   framing_err
);

   localparam int NUM_DATA_LINES = data_lines_for(DATA_BYTES);
   localparam int PARITY_MEMS    = DATA_BYTES / PARITY_BYTES;
   localparam int PARITY_SHIFT   = $clog2(PARITY_MEMS);

   logic datap_ctrl_req_zero;
   logic datap_ctrl_last_data_line;
   logic datap_ctrl_last_parity_line;
   logic ctrl_datap_req_acc;
   logic ctrl_datap_data_acc;
   logic ctrl_datap_parity_acc;

   rs_decode_stream_in_ctrl u_ctrl (
      .clk                         (clk),
      .rst                         (rst),
      .src_decode_req_val          (src_decode_req_val),
      .src_decode_req_rdy          (src_decode_req_rdy),
      .src_decode_data_val         (src_decode_data_val),
      .src_decode_data_rdy         (src_decode_data_rdy),
      .decode_req_done_val         (decode_req_done_val),
      .decode_req_done_rdy         (decode_req_done_rdy),
      .datap_ctrl_req_zero         (datap_ctrl_req_zero),
      .datap_ctrl_last_data_line   (datap_ctrl_last_data_line),
      .datap_ctrl_last_parity_line (datap_ctrl_last_parity_line),
      .ctrl_datap_req_acc          (ctrl_datap_req_acc),
      .ctrl_datap_data_acc         (ctrl_datap_data_acc),
      .ctrl_datap_parity_acc       (ctrl_datap_parity_acc)
   );

   rs_decode_stream_in_datap #(
      .NUM_REQ_BLOCKS   (NUM_REQ_BLOCKS),
      .NUM_REQ_BLOCKS_W (NUM_REQ_BLOCKS_W),
      .DATA_W           (DATA_W),
      .NUM_DATA_LINES   (NUM_DATA_LINES),
      .NUM_DATA_LINES_W (NUM_DATA_LINES_W),
      .PARITY_MEMS      (PARITY_MEMS),
      .PARITY_SHIFT     (PARITY_SHIFT)
   ) u_datap (
      .clk                         (clk),
      .rst                         (rst),
      .src_decode_req_num_blocks   (src_decode_req_num_blocks),
      .src_decode_data             (src_decode_data),
      .src_decode_data_last        (src_decode_data_last),
      .ctrl_datap_req_acc          (ctrl_datap_req_acc),
      .ctrl_datap_data_acc         (ctrl_datap_data_acc),
      .ctrl_datap_parity_acc       (ctrl_datap_parity_acc),
      .datap_ctrl_req_zero         (datap_ctrl_req_zero),
      .datap_ctrl_last_data_line   (datap_ctrl_last_data_line),
      .datap_ctrl_last_parity_line (datap_ctrl_last_parity_line),
      .data_mem_wr_val             (data_mem_wr_val),
      .data_mem_wr_addr            (data_mem_wr_addr),
      .data_mem_wr_data            (data_mem_wr_data),
      .parity_mem_wr_val           (parity_mem_wr_val),
      .parity_mem_wr_addr          (parity_mem_wr_addr),
      .parity_mem_wr_data          (parity_mem_wr_data),
      .decode_req_done_num_blocks  (decode_req_done_num_blocks),
      .framing_err                 (framing_err)
   );

endmodule

// File: tb/tb_rs_decode_stream_in.sv
// tb/tb_rs_decode_stream_in.sv - randomized directed bench with reference request model
module tb_rs_decode_stream_in;

   localparam int NB_W = 4;
   localparam int NL_W = 2;
   localparam int DW   = 256;

   logic              clk = 1'b0;
   logic              rst;
   logic              src_decode_req_val;
   logic [NB_W:0]     src_decode_req_num_blocks;
   logic              src_decode_req_rdy;
   logic              src_decode_data_val;
   logic [DW-1:0]     src_decode_data;
   logic              src_decode_data_last;
   logic              src_decode_data_rdy;
   logic              data_mem_wr_val;
   logic [NB_W+NL_W-1:0] data_mem_wr_addr;
   logic [DW-1:0]     data_mem_wr_data;
   logic              parity_mem_wr_val;
   logic [NB_W-1:0]   parity_mem_wr_addr;
   logic [DW-1:0]     parity_mem_wr_data;
   logic              decode_req_done_val;
   logic [NB_W:0]     decode_req_done_num_blocks;
   logic              decode_req_done_rdy;
   logic              framing_err;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   rs_decode_stream_in dut (
      .clk                        (clk),
      .rst                        (rst),
      .src_decode_req_val         (src_decode_req_val),
      .src_decode_req_num_blocks  (src_decode_req_num_blocks),
      .src_decode_req_rdy         (src_decode_req_rdy),
      .src_decode_data_val        (src_decode_data_val),
      .src_decode_data            (src_decode_data),
      .src_decode_data_last       (src_decode_data_last),
      .src_decode_data_rdy        (src_decode_data_rdy),
      .data_mem_wr_val            (data_mem_wr_val),
      .data_mem_wr_addr           (data_mem_wr_addr),
      .data_mem_wr_data           (data_mem_wr_data),
      .parity_mem_wr_val          (parity_mem_wr_val),
      .parity_mem_wr_addr         (parity_mem_wr_addr),
      .parity_mem_wr_data         (parity_mem_wr_data),
      .decode_req_done_val        (decode_req_done_val),
      .decode_req_done_num_blocks (decode_req_done_num_blocks),
      .decode_req_done_rdy        (decode_req_done_rdy),
      .framing_err                (framing_err)
   );

   task automatic chk(input string tag, input logic [DW-1:0] observed, input logic [DW-1:0] expected);
      checks++;
      assert (observed === expected) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   // One full request: the model derives every expected write from the block count alone.
   // abort_after >= 0 stops after that many accepted lines, leaving the DUT mid-request.
   task automatic do_request(input int nb_in, input int err_line, input int val_pct,
                             input int hold, input int abort_after);
      int nb, ndata, npl, total, idx, cyc;
      logic hs;
      nb    = (nb_in > 16) ? 16 : nb_in;
      ndata = nb * 4;
      npl   = (nb + 3) / 4;
      total = ndata + npl;

      @(negedge clk);
      src_decode_req_val        = 1'b1;
      src_decode_req_num_blocks = 5'(nb_in);
      #1;
      chk("req_rdy_idle", src_decode_req_rdy, 1);
      chk("data_rdy_idle", src_decode_data_rdy, 0);
      @(negedge clk);
      src_decode_req_val        = 1'b0;
      src_decode_req_num_blocks = '0;

      idx = 0;
      cyc = 0;
      while (idx < total && cyc < 2000) begin
         if (abort_after >= 0 && idx == abort_after) return;
         src_decode_data_val  = ($urandom_range(99) < val_pct);
         src_decode_data      = {$urandom, $urandom, $urandom, $urandom,
                                 $urandom, $urandom, $urandom, $urandom};
         src_decode_data_last = ((idx == total - 1) != (idx == err_line));
         #1;
         hs = src_decode_data_val;
         chk("data_rdy_busy", src_decode_data_rdy, 1);
         chk("req_rdy_busy", src_decode_req_rdy, 0);
         chk("done_val_busy", decode_req_done_val, 0);
         chk("data_wr_val", data_mem_wr_val, (hs && idx < ndata));
         chk("parity_wr_val", parity_mem_wr_val, (hs && idx >= ndata));
         if (hs && idx < ndata) begin
            chk("data_wr_addr", data_mem_wr_addr, idx);
            chk("data_wr_data", data_mem_wr_data, src_decode_data);
         end
         if (hs && idx >= ndata) begin
            chk("parity_wr_addr", parity_mem_wr_addr, idx - ndata);
            chk("parity_wr_data", parity_mem_wr_data, src_decode_data);
         end
         chk("framing_err", framing_err, (hs && idx == err_line));
         if (hs) idx++;
         cyc++;
         @(negedge clk);
      end
      src_decode_data_val  = 1'b0;
      src_decode_data_last = 1'b0;
      if (idx < total) chk("stream_timeout", idx, total);

      #1;
      chk("done_val", decode_req_done_val, 1);
      chk("done_num_blocks", decode_req_done_num_blocks, nb);
      chk("req_rdy_done", src_decode_req_rdy, 0);
      chk("data_rdy_done", src_decode_data_rdy, 0);
      chk("data_wr_done", data_mem_wr_val, 0);
      chk("parity_wr_done", parity_mem_wr_val, 0);
      repeat (hold) begin
         @(negedge clk);
         #1;
         chk("done_val_hold", decode_req_done_val, 1);
         chk("req_rdy_hold", src_decode_req_rdy, 0);
         chk("data_rdy_hold", src_decode_data_rdy, 0);
      end
      @(negedge clk);
      decode_req_done_rdy = 1'b1;
      #1;
      chk("done_val_take", decode_req_done_val, 1);
      @(negedge clk);
      decode_req_done_rdy = 1'b0;
      #1;
      chk("req_rdy_after", src_decode_req_rdy, 1);
      chk("done_val_after", decode_req_done_val, 0);
   endtask

   initial begin
      rst                       = 1'b1;
      src_decode_req_val        = 1'b0;
      src_decode_req_num_blocks = '0;
      src_decode_data_val       = 1'b0;
      src_decode_data           = '0;
      src_decode_data_last      = 1'b0;
      decode_req_done_rdy       = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      #1;
      chk("rst_req_rdy", src_decode_req_rdy, 1);
      chk("rst_data_rdy", src_decode_data_rdy, 0);
      chk("rst_data_wr", data_mem_wr_val, 0);
      chk("rst_parity_wr", parity_mem_wr_val, 0);
      chk("rst_done_val", decode_req_done_val, 0);
      chk("rst_framing", framing_err, 0);

      do_request(2, -1, 100, 0, -1);
      do_request(5, -1, 100, 0, -1);
      do_request(7, -1, 60, 3, -1);
      do_request(0, -1, 100, 0, -1);
      do_request(17, -1, 100, 0, -1);
      do_request(3, 3, 100, 0, -1);
      repeat (4) begin
         do_request(int'($urandom_range(18)), -1, 70, int'($urandom_range(2)), -1);
      end

      do_request(3, -1, 100, 0, 5);
      rst                 = 1'b1;
      src_decode_data_val = 1'b1;
      @(negedge clk);
      rst                 = 1'b0;
      src_decode_data_val = 1'b0;
      #1;
      chk("midrst_req_rdy", src_decode_req_rdy, 1);
      chk("midrst_data_rdy", src_decode_data_rdy, 0);
      chk("midrst_done_val", decode_req_done_val, 0);
      chk("midrst_data_wr", data_mem_wr_val, 0);
      do_request(1, -1, 100, 0, -1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/rs_decode_stream_in.md
Name: rs_decode_stream_in

Overview:
- Receive-side counterpart of the RS encode stream-out path.
- Ingests one encoded request stream per metadata request: all data lines of every block first, then the packed parity lines.
- Writes data lines into the data buffer at block/line addresses and parity lines into the parity memory.
- Then hands a completion token to the decode controller, which launches per-block decode.

Parameters:
- NUM_REQ_BLOCKS, 16, max blocks per request.
- NUM_REQ_BLOCKS_W, $clog2(NUM_REQ_BLOCKS), block index width.
- DATA_W, 256, stream line width in bits.
- DATA_BYTES, DATA_W/8, bytes per line.

Ports:
- clk  in  1  clock
- rst  in  1  reset; synchronous, active-high
- src_decode_req_val  in  1  request metadata valid
- src_decode_req_num_blocks  in  NUM_REQ_BLOCKS_W+1  blocks in request
- src_decode_req_rdy  out  1  metadata accepted
- src_decode_data_val  in  1  stream line valid
- src_decode_data  in  DATA_W  stream line
- src_decode_data_last  in  1  sender's end-of-request marker
- src_decode_data_rdy  out  1  stream line accepted
- data_mem_wr_val  out  1  data buffer write strobe
- data_mem_wr_addr  out  NUM_REQ_BLOCKS_W+NUM_DATA_LINES_W  block*NUM_DATA_LINES+line
- data_mem_wr_data  out  DATA_W  line written
- parity_mem_wr_val  out  1  parity memory write strobe
- parity_mem_wr_addr  out  NUM_REQ_BLOCKS_W  parity line index
- parity_mem_wr_data  out  DATA_W  parity line (PARITY_MEMS packed block parities, block 0 in LSBs)
- decode_req_done_val  out  1  request fully stored
- decode_req_done_num_blocks  out  NUM_REQ_BLOCKS_W+1  stored block count
- decode_req_done_rdy  in  1  decode controller takes token
- framing_err  out  1  one-cycle pulse on last/count mismatch

Behaviour:
- Derived values: NUM_DATA_LINES = RS_DATA_BYTES/DATA_BYTES; PARITY_MEMS = DATA_BYTES/PARITY_BYTES; PARITY_SHIFT = $clog2(PARITY_MEMS).
- num_parity_lines = (num_blocks + PARITY_MEMS-1) >> PARITY_SHIFT (ceiling).
- FSM states IDLE, WR_DATA, WR_PARITY, DONE.
  - IDLE: req_rdy=1. On req_val, latch num_blocks (clamped to NUM_REQ_BLOCKS) and zero block, line and parity counters. Next state is DONE if num_blocks==0, else WR_DATA.
  - WR_DATA: data_rdy=1. On each val&rdy, write data_mem the same cycle (zero latency) at {block_cnt, line_cnt}.
    - line_cnt wraps at NUM_DATA_LINES-1 and increments block_cnt.
    - On the last line of the last block, go to WR_PARITY.
  - WR_PARITY: data_rdy=1. Each accepted line writes parity_mem at parity_cnt, then parity_cnt++. Go to DONE after line num_parity_lines-1.
  - DONE: done_val=1, done_num_blocks=latched value. Stay until done_rdy, then go to IDLE.
- Output gating:
  - data_rdy is 0 in IDLE and DONE. req_rdy is 0 outside IDLE.
  - Write strobes assert only on an accepted handshake.
  - wr_data is passed straight through from src_decode_data.
- Memory writes are always accepted; there is no memory backpressure.
- framing_err:
  - Pulses when an accepted line's src_decode_data_last differs from the expected value. Expected is 1 only on the final parity line.
  - Counting and writes proceed unchanged; the count is authoritative.
- A new request is accepted no earlier than the cycle after done handshake, since req_rdy is only high in IDLE.
- Reset, including mid-request: state=IDLE, all counters 0, latched count 0, all outputs 0 except req_rdy=1. A partially written request is abandoned.

Decomposition:
- Shared package rs_pkg holds RS_DATA_BYTES (128), PARITY_BYTES (8), derived NUM_DATA_LINES_W, and the FSM state enum.
- Split: rs_decode_stream_in_ctrl (FSM, handshakes) plus rs_decode_stream_in_datap (counters, address generation, last-line compares).
- Control/datapath signals are named ctrl_datap_* / datap_ctrl_*.

Test Plan:
- Reset: after reset, req_rdy=1 and data_rdy, wr_vals, done_val, framing_err all 0.
- num_blocks=2: 8 data lines → data addrs 0..7; 1 parity line with last=1 → parity addr 0; done_val with num_blocks=2; framing_err never pulses.
- num_blocks=5: 20 data lines (block 4 at addrs 16..19); 2 parity lines → parity addrs 0,1; done on the cycle after the 2nd parity line.
- Backpressure: data_val toggled randomly → strobes only on handshakes, addresses contiguous. done_rdy held low 3 cycles → done_val held, req_rdy=0, data_rdy=0.
- num_blocks=0: done_val the cycle after request, no writes; num_blocks=17 is clamped to 16 (4 parity lines).
- Errors: last=1 on data line 3 → single framing_err pulse, writes unaffected. rst asserted mid-WR_DATA → next cycle IDLE, and a fresh request restarts at data addr 0.
